card_dealer: RTL and testbench
==============================

# card_dealer

Random card source for the blackjack game. It keeps a 52-card deck state with a per-card "used" mask and a free-running 16-bit LFSR. On request it deals one not-yet-dealt card and returns the card index, rank and blackjack points. It sits directly upstream of the card draw stage: `card_id` selects the card image, whose pixel data the draw stage then fetches and overlays.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value; must be non-zero.
- `clk`  in  1  posedge clock.
- `rst`  in  1  synchronous, active-low reset.
- `shuffle`  in  1  single-cycle pulse: return all 52 cards to the deck.
- `deal_req`  in  1  single-cycle pulse: deal one card.
- `busy`  out  1  deal in progress; `deal_req` is ignored while high.
- `card_valid`  out  1  one-cycle pulse: the card outputs below hold a new card.
- `card_id`  out  6  card index, 0..51; suit = id/13, rank index = id%13.
- `card_rank`  out  4  1 = Ace … 13 = King.
- `card_points`  out  4  Ace = 11; 2..10 = rank; J/Q/K = 10.
- `cards_left`  out  6  undealt cards, 0..52.
- `deck_empty`  out  1  high when `cards_left` == 0.
- `deal_err`  out  1  one-cycle pulse: `deal_req` was received while `deck_empty` was high.

## Operation
- **LFSR**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every cycle except during reset; never stalls.
- **FSM states:** IDLE, SCAN, OUT.
- **IDLE**
  - On `deal_req` with `deck_empty`=0: `cand` = `lfsr[5:0]`, minus 52 if ≥ 52 (result 0..51), registered. Next state SCAN.
  - On `deal_req` with `deck_empty`=1: pulse `deal_err` next cycle; state unchanged.
- **SCAN** (one `used` lookup per cycle)
  - If `used[cand]`: `cand` = (`cand` == 51) ? 0 : `cand`+1, stay in SCAN.
  - Else: set `used[cand]`, load `card_id`/`card_rank`/`card_points` from `cand`, decrement `cards_left`, next state OUT.
  - Termination is guaranteed because SCAN is entered only with `cards_left` ≥ 1.
- **OUT:** `card_valid`=1 for exactly this cycle; next state IDLE.
- **Output holding:** `card_id`, `card_rank` and `card_points` are registered and hold until the next card is loaded.
- **shuffle** has priority in every state:
  - clears `used`; `cards_left` = 52; state = IDLE.
  - any deal in progress is aborted: no `card_valid`, no decrement.
  - `deal_req` in the same cycle is dropped.
  - the LFSR is not reseeded.
- **Arithmetic**
  - rank index = `card_id` mod 13, computed by comparison/subtraction of 13, 26, 39; no divider.
  - `card_points` derives from `card_rank`.
- **Registered outputs:** `deck_empty` is registered from the next value of `cards_left`; `busy` = (state != IDLE), registered.

## Timing
- **Reset values:** state IDLE, `lfsr` = SEED, `used` = 0, `cards_left` = 52, `card_id`/`card_rank`/`card_points` = 0; `busy`, `card_valid`, `deck_empty`, `deal_err` = 0.
- **Reset mid-deal:** takes effect on the next edge; no `card_valid`.
- **Deal latency:** `deal_req` sampled at edge N in IDLE gives:
  - `busy` high from N+1;
  - `card_valid` high in cycle N+2+k, where k = number of occupied slots skipped;
  - `busy` low from N+3+k.
- **Throughput:** `cards_left`/`deck_empty` update on the same edge that raises `card_valid`. The earliest next accepted `deal_req` is at edge N+3+k.
- **Worst case:** k = 51, so latency 53 cycles.
- **deal_err:** high in cycle N+1 only; `busy` stays 0.
- **shuffle:** sampled at edge N; `cards_left` = 52, `deck_empty` = 0 and `busy` = 0 from N+1.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, release → all outputs at reset values; `cards_left`=52; `lfsr` = 16'hACE1 on the first cycle after release.
- **Single deal:** `deal_req` at edge N into a fresh deck → `busy` at N+1, `card_valid` at N+2; `card_id` < 52; `cards_left`=51; rank/points consistent with id.
- **Full deck:** issue 52 deals → 52 distinct `card_id` values covering 0..51; `deck_empty`=1 after the 52nd. A 53rd `deal_req` → `deal_err` one cycle, no `card_valid`, `busy`=0.
- **Encoding (force `cand` via backdoor):**
  - id 0 → rank 1, points 11
  - id 12 → rank 13, points 10
  - id 22 → rank 10, points 10
  - id 40 → rank 2, points 2
- **Wrap-around scan:** pre-mark `used[50]`,`used[51]`, force `cand`=50 → `card_id`=0 after k=2, `card_valid` at N+4.
- **Shuffle mid-SCAN and reset mid-SCAN:**
  - `shuffle` during a long scan → no `card_valid`, `cards_left`=52, `busy`=0 next cycle.
  - repeat with `rst`=0 instead → same result, and `lfsr`=SEED.

Source files
------------

// File: rtl/card_dealer_if.sv
// Deal/shuffle handshake and card result bundle for the card dealer.
interface card_dealer_if;
    logic       shuffle;
    logic       deal_req;
    logic       busy;
    logic       card_valid;
    logic [5:0] card_id;
    logic [3:0] card_rank;
    logic [3:0] card_points;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       deal_err;

    modport master (
        output shuffle, deal_req,
        input  busy, card_valid, card_id, card_rank, card_points,
        input  cards_left, deck_empty, deal_err
    );

    modport slave (
        input  shuffle, deal_req,
        output busy, card_valid, card_id, card_rank, card_points,
        output cards_left, deck_empty, deal_err
    );
endinterface

// File: rtl/card_dealer.sv
// 52-card random dealer: free-running LFSR picks a start slot, then a
// linear scan over the used mask finds the next undealt card.
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    card_dealer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [51:0] used_q, used_d;
    logic [5:0]  cand_q, cand_d;
    logic [5:0]  left_q, left_d;
    logic [5:0]  id_q, id_d;
    logic [3:0]  rank_q, rank_d;
    logic [3:0]  pts_q, pts_d;
    logic        busy_q, valid_q, empty_q, err_q, err_d;

    logic [5:0]  raw;
    logic [5:0]  start_cand;
    logic [5:0]  idx;
    logic [3:0]  cand_rank;
    logic [3:0]  cand_pts;

    // Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    assign raw        = lfsr_q[5:0];
    assign start_cand = (raw >= 6'd52) ? raw - 6'd52 : raw;

    always_comb begin
        idx = cand_q;
        if (cand_q >= 6'd39)      idx = cand_q - 6'd39;
        else if (cand_q >= 6'd26) idx = cand_q - 6'd26;
        else if (cand_q >= 6'd13) idx = cand_q - 6'd13;
    end

    assign cand_rank = 4'(idx + 6'd1);
    assign cand_pts  = (cand_rank == 4'd1) ? 4'd11 :
                       (cand_rank > 4'd10) ? 4'd10 : cand_rank;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        used_d  = used_q;
        left_d  = left_q;
        id_d    = id_q;
        rank_d  = rank_q;
        pts_d   = pts_q;
        err_d   = 1'b0;
        if (bus.shuffle) begin
            state_d = IDLE;
            used_d  = '0;
            left_d  = 6'd52;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.deal_req) begin
                        if (empty_q) begin
                            err_d = 1'b1;
                        end else begin
                            cand_d  = start_cand;
                            state_d = SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (used_q[cand_q]) begin
                        cand_d = (cand_q == 6'd51) ? 6'd0 : cand_q + 6'd1;
                    end else begin
                        used_d[cand_q] = 1'b1;
                        id_d    = cand_q;
                        rank_d  = cand_rank;
                        pts_d   = cand_pts;
                        left_d  = left_q - 6'd1;
                        state_d = OUT;
                    end
                end
                OUT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            used_q  <= '0;
            cand_q  <= '0;
            left_q  <= 6'd52;
            id_q    <= '0;
            rank_q  <= '0;
            pts_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            cand_q  <= cand_d;
            left_q  <= left_d;
            id_q    <= id_d;
            rank_q  <= rank_d;
            pts_q   <= pts_d;
            busy_q  <= (state_d != IDLE);
            valid_q <= (state_d == OUT);
            empty_q <= (left_d == 6'd0);
            err_q   <= err_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.card_valid  = valid_q;
    assign bus.card_id     = id_q;
    assign bus.card_rank   = rank_q;
    assign bus.card_points = pts_q;
    assign bus.cards_left  = left_q;
    assign bus.deck_empty  = empty_q;
    assign bus.deal_err    = err_q;
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, dealing, encoding, wrap scan,
// abort by shuffle and by reset.
module tb_card_dealer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [5:0]  fv;
    logic [51:0] ufv;

    card_dealer_if bus();

    card_dealer #(.SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.shuffle  = 1'b0;
        bus.deal_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        n_cmp++;
        if (dut.lfsr_q !== 16'hACE1) begin
            n_bad++;
            $display("FAIL reset_lfsr got %h want ace1", dut.lfsr_q);
        end
        n_cmp++;
        if (bus.cards_left !== 6'd52) begin
            n_bad++;
            $display("FAIL reset_left got %0d want 52", bus.cards_left);
        end
        n_cmp++;
        if ({bus.busy, bus.card_valid, bus.deck_empty, bus.deal_err} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000",
                     {bus.busy, bus.card_valid, bus.deck_empty, bus.deal_err});
        end
        n_cmp++;
        if ({bus.card_id, bus.card_rank, bus.card_points} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_card got %0d/%0d/%0d want 0/0/0",
                     bus.card_id, bus.card_rank, bus.card_points);
        end
    endtask

    task automatic test_single_deal();
        int r;
        int p;
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.card_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_n1 busy=%b valid=%b want 1 0", bus.busy, bus.card_valid);
        end
        tick();
        n_cmp++;
        if (bus.card_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_valid got %b want 1", bus.card_valid);
        end
        n_cmp++;
        if (bus.card_id >= 6'd52 || bus.cards_left !== 6'd51) begin
            n_bad++;
            $display("FAIL single_id id=%0d left=%0d want <52 and 51", bus.card_id, bus.cards_left);
        end
        r = (int'(bus.card_id) % 13) + 1;
        p = (r == 1) ? 11 : (r > 10) ? 10 : r;
        n_cmp++;
        if (int'(bus.card_rank) != r || int'(bus.card_points) != p) begin
            n_bad++;
            $display("FAIL single_enc got %0d/%0d want %0d/%0d",
                     bus.card_rank, bus.card_points, r, p);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.card_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end busy=%b valid=%b want 0 0", bus.busy, bus.card_valid);
        end
    endtask

    task automatic test_full_deck();
        logic [51:0] seen;
        bit          hit;
        int          r;
        int          p;
        seen = '0;
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        for (int i = 0; i < 52; i++) begin
            bus.deal_req = 1'b1;
            tick();
            bus.deal_req = 1'b0;
            for (int w = 0; w < 60 && bus.card_valid !== 1'b1; w++) tick();
            n_cmp++;
            if (bus.card_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL deck_timeout deal %0d no valid within 60", i);
            end
            n_cmp++;
            if (bus.card_id >= 6'd52 || seen[bus.card_id] !== 1'b0) begin
                n_bad++;
                $display("FAIL deck_dup deal %0d id=%0d repeated or out of range", i, bus.card_id);
            end else begin
                seen[bus.card_id] = 1'b1;
            end
            n_cmp++;
            if (int'(bus.cards_left) != 51 - i) begin
                n_bad++;
                $display("FAIL deck_left deal %0d got %0d want %0d", i, bus.cards_left, 51 - i);
            end
            r = (int'(bus.card_id) % 13) + 1;
            p = (r == 1) ? 11 : (r > 10) ? 10 : r;
            n_cmp++;
            if (int'(bus.card_rank) != r || int'(bus.card_points) != p) begin
                n_bad++;
                $display("FAIL deck_enc id=%0d got %0d/%0d want %0d/%0d",
                         bus.card_id, bus.card_rank, bus.card_points, r, p);
            end
            tick();
        end
        n_cmp++;
        if (seen !== 52'hF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL deck_cover got %h want all ones", seen);
        end
        n_cmp++;
        if (bus.deck_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL deck_empty got %b want 1", bus.deck_empty);
        end
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        n_cmp++;
        if (bus.deal_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse err=%b busy=%b want 1 0", bus.deal_err, bus.busy);
        end
        hit = 1'b0;
        tick();
        n_cmp++;
        if (bus.deal_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_width got %b want 0", bus.deal_err);
        end
        for (int w = 0; w < 5; w++) begin
            if (bus.card_valid !== 1'b0 || bus.busy !== 1'b0) hit = 1'b1;
            tick();
        end
        n_cmp++;
        if (hit) begin
            n_bad++;
            $display("FAIL err_novalid got activity want none");
        end
    endtask

    task automatic forced_deal(input logic [5:0] id);
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        fv = id;
        force dut.cand_q = fv;
        tick();
        release dut.cand_q;
    endtask

    task automatic test_encoding();
        logic [5:0] ids[4]  = '{6'd0, 6'd12, 6'd22, 6'd40};
        logic [3:0] rks[4]  = '{4'd1, 4'd13, 4'd10, 4'd2};
        logic [3:0] pts[4]  = '{4'd11, 4'd10, 4'd10, 4'd2};
        for (int i = 0; i < 4; i++) begin
            forced_deal(ids[i]);
            n_cmp++;
            if (bus.card_valid !== 1'b1 || bus.card_id !== ids[i]
                || bus.card_rank !== rks[i] || bus.card_points !== pts[i]) begin
                n_bad++;
                $display("FAIL enc_%0d v=%b id=%0d r=%0d p=%0d want 1 %0d %0d %0d",
                         i, bus.card_valid, bus.card_id, bus.card_rank, bus.card_points,
                         ids[i], rks[i], pts[i]);
            end
            tick();
        end
    endtask

    task automatic test_wrap_scan();
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        fv  = 6'd50;
        ufv = '0;
        ufv[50] = 1'b1;
        ufv[51] = 1'b1;
        force dut.cand_q = fv;
        force dut.used_q = ufv;
        @(negedge clk);
        release dut.cand_q;
        tick();
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.card_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_early busy=%b valid=%b want 1 0", bus.busy, bus.card_valid);
        end
        tick();
        n_cmp++;
        if (bus.card_valid !== 1'b1 || bus.card_id !== 6'd0 || bus.card_rank !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap_card v=%b id=%0d r=%0d want 1 0 1",
                     bus.card_valid, bus.card_id, bus.card_rank);
        end
        release dut.used_q;
        tick();
    endtask

    task automatic start_long_scan();
        forced_deal(6'd5);
        tick();
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        fv  = 6'd0;
        ufv = 52'hF_FFFF_FFFF_FFFF;
        force dut.cand_q = fv;
        force dut.used_q = ufv;
        repeat (5) tick();
    endtask

    task automatic test_shuffle_mid_scan();
        bit hit;
        start_long_scan();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.cards_left !== 6'd51) begin
            n_bad++;
            $display("FAIL shuf_pre busy=%b left=%0d want 1 51", bus.busy, bus.cards_left);
        end
        @(negedge clk);
        release dut.cand_q;
        release dut.used_q;
        bus.shuffle  = 1'b1;
        bus.deal_req = 1'b1;
        tick();
        bus.shuffle  = 1'b0;
        bus.deal_req = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.card_valid !== 1'b0
            || bus.cards_left !== 6'd52 || bus.deck_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL shuf_abort busy=%b valid=%b left=%0d empty=%b want 0 0 52 0",
                     bus.busy, bus.card_valid, bus.cards_left, bus.deck_empty);
        end
        hit = 1'b0;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (bus.card_valid !== 1'b0 || bus.busy !== 1'b0) hit = 1'b1;
        end
        n_cmp++;
        if (hit) begin
            n_bad++;
            $display("FAIL shuf_quiet got activity after abort want none");
        end
    endtask

    task automatic test_reset_mid_scan();
        bit hit;
        start_long_scan();
        @(negedge clk);
        release dut.cand_q;
        release dut.used_q;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.card_valid !== 1'b0 || bus.cards_left !== 6'd52) begin
            n_bad++;
            $display("FAIL rst_abort busy=%b valid=%b left=%0d want 0 0 52",
                     bus.busy, bus.card_valid, bus.cards_left);
        end
        n_cmp++;
        if (dut.lfsr_q !== 16'hACE1) begin
            n_bad++;
            $display("FAIL rst_lfsr got %h want ace1", dut.lfsr_q);
        end
        hit = 1'b0;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (bus.card_valid !== 1'b0 || bus.busy !== 1'b0) hit = 1'b1;
        end
        n_cmp++;
        if (hit) begin
            n_bad++;
            $display("FAIL rst_quiet got activity after reset want none");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        fv    = '0;
        ufv   = '0;
        test_reset();
        test_single_deal();
        test_full_deck();
        test_encoding();
        test_wrap_scan();
        test_shuffle_mid_scan();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
